// File: rtl/fifo_rd_tx_feeder_pkg.sv
// Shared definitions for the FIFO read-side TX feeder: word width, FSM encodings,
// counter sizing helpers.
package fifo_rd_tx_feeder_pkg;

    // Word width shared by the FIFO memory and the UART transmitter
    localparam int unsigned FEEDER_DATA_WIDTH = 8;

    // Width of the completed-frame counter
    localparam int unsigned SENT_COUNT_W = 16;

    // FSM encodings (plain constants so legacy blocks can share them)
    localparam int unsigned STATE_W = 3;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    // Bits needed to count 0..n; never less than one bit so a zero count still elaborates
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    // Terminal value of a counter that spans n cycles starting from zero
    function automatic int unsigned cnt_last(input int unsigned n);
        return (n > 0) ? (n - 1) : 0;
    endfunction

endpackage

// File: rtl/fifo_rd_tx_feeder_if.sv
// FIFO read port plus UART TX handshake seen by the feeder.
// master = the feeder, slave = the FIFO/TX side.
interface fifo_rd_tx_feeder_if
    import fifo_rd_tx_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FEEDER_DATA_WIDTH
);

    logic                  rempty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rinc;
    logic                  tx_busy;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_data_valid;

    modport master (
        input  rempty,
        input  rdata,
        input  tx_busy,
        output rinc,
        output tx_data,
        output tx_data_valid
    );

    modport slave (
        output rempty,
        output rdata,
        output tx_busy,
        input  rinc,
        input  tx_data,
        input  tx_data_valid
    );

endinterface

// File: rtl/fifo_rd_tx_feeder.sv
// Read-domain consumer of the async FIFO: pops one word per frame, hands it to the
// UART TX with a valid/busy handshake, optionally idles between frames, flags TX
// that never acknowledges and counts completed frames.
module fifo_rd_tx_feeder
    import fifo_rd_tx_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = FEEDER_DATA_WIDTH,
    parameter int unsigned GAP_CYCLES   = 0,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                    i_rclk,
    input  logic                    i_rrst,
    input  logic                    i_enable,
    fifo_rd_tx_feeder_if.master     io_bus,
    output logic                    o_tx_error,
    output logic [SENT_COUNT_W-1:0] o_sent_count
);

    localparam int unsigned TO_W     = cnt_width(BUSY_TIMEOUT);
    localparam int unsigned TO_LAST  = cnt_last(BUSY_TIMEOUT);
    localparam int unsigned GAP_W    = cnt_width(GAP_CYCLES);
    localparam int unsigned GAP_LAST = cnt_last(GAP_CYCLES);

    logic [STATE_W-1:0]      r_state;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_tx_data_valid;
    logic                    r_tx_error;
    logic [SENT_COUNT_W-1:0] r_sent_count;
    logic [TO_W-1:0]         r_to_cnt;
    logic [GAP_W-1:0]        r_gap_cnt;

    logic [STATE_W-1:0]      w_state_nxt;
    logic                    w_rinc;
    logic [DATA_WIDTH-1:0]   w_tx_data_nxt;
    logic                    w_tx_data_valid_nxt;
    logic                    w_tx_error_nxt;
    logic [SENT_COUNT_W-1:0] w_sent_count_nxt;
    logic [TO_W-1:0]         w_to_cnt_nxt;
    logic [GAP_W-1:0]        w_gap_cnt_nxt;

    // State and registered outputs; reset drops any held word
    always_ff @(posedge i_rclk) begin
        if (i_rrst) begin
            r_state         <= ST_IDLE;
            r_tx_data       <= '0;
            r_tx_data_valid <= 1'b0;
            r_tx_error      <= 1'b0;
            r_sent_count    <= '0;
            r_to_cnt        <= '0;
            r_gap_cnt       <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_tx_data       <= w_tx_data_nxt;
            r_tx_data_valid <= w_tx_data_valid_nxt;
            r_tx_error      <= w_tx_error_nxt;
            r_sent_count    <= w_sent_count_nxt;
            r_to_cnt        <= w_to_cnt_nxt;
            r_gap_cnt       <= w_gap_cnt_nxt;
        end
    end

    // Next state, pop request and next register values
    always_comb begin
        w_state_nxt         = r_state;
        w_rinc              = 1'b0;
        w_tx_data_nxt       = r_tx_data;
        w_tx_data_valid_nxt = 1'b0;
        w_tx_error_nxt      = r_tx_error;
        w_sent_count_nxt    = r_sent_count;
        w_to_cnt_nxt        = r_to_cnt;
        w_gap_cnt_nxt       = r_gap_cnt;

        case (r_state)
            ST_IDLE: begin
                // Empty and enable are only looked at here, so a stale empty flag
                // during a frame can never cause a second pop.
                if (i_enable && !io_bus.rempty && !i_rrst) begin
                    w_rinc        = 1'b1;
                    w_tx_data_nxt = io_bus.rdata;
                    w_state_nxt   = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (!io_bus.tx_busy) begin
                    w_tx_data_valid_nxt = 1'b1;
                    w_to_cnt_nxt        = '0;
                    w_state_nxt         = ST_WAIT_BUSY;
                end
            end

            ST_WAIT_BUSY: begin
                // An acknowledge on the last allowed cycle still wins over the timeout
                if (io_bus.tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_to_cnt == TO_W'(TO_LAST)) begin
                    w_tx_error_nxt = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (!io_bus.tx_busy) begin
                    w_sent_count_nxt = r_sent_count + SENT_COUNT_W'(1);
                    if (GAP_CYCLES > 0) begin
                        w_gap_cnt_nxt = '0;
                        w_state_nxt   = ST_GAP;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign io_bus.rinc          = w_rinc;
    assign io_bus.tx_data       = r_tx_data;
    assign io_bus.tx_data_valid = r_tx_data_valid;
    assign o_tx_error           = r_tx_error;
    assign o_sent_count         = r_sent_count;

endmodule

// File: tb/tb_fifo_rd_tx_feeder.sv
// Bench for fifo_rd_tx_feeder (gap of 3 cycles, busy timeout of 4).
module tb_fifo_rd_tx_feeder;

    localparam int unsigned GAP = 3;
    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        tx_error;
    logic [15:0] sent_count;

    fifo_rd_tx_feeder_if #(.DATA_WIDTH(8)) bus ();

    fifo_rd_tx_feeder #(
        .DATA_WIDTH  (8),
        .GAP_CYCLES  (GAP),
        .BUSY_TIMEOUT(TMO)
    ) dut (
        .i_rclk      (clk),
        .i_rrst      (rst),
        .i_enable    (enable),
        .io_bus      (bus),
        .o_tx_error  (tx_error),
        .o_sent_count(sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        emp;
        logic [7:0]  rdata;
        logic        busy;
        logic        x_rinc;
        logic [7:0]  x_data;
        logic        x_valid;
        logic        x_err;
        logic [15:0] x_sent;
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_errors = 0;
    int n        = 0;

    // Reference model state (transaction level)
    logic [7:0]  q[$];
    logic [7:0]  m_data;
    logic        m_err;
    logic [15:0] m_sent;
    int ph;          // 0 idle/gap, 1 word held, 2 valid sent awaiting ack, 3 TX busy
    int idle_at;     // first cycle at which a new pop is allowed
    int ack_cnt, rise, stall_left, busy_left;
    int dut_pops, last_fall, min_gap;

    function automatic vec_t mk(input logic r, input logic e, input logic emp,
                                input logic [7:0] d, input logic b,
                                input logic xr, input logic [7:0] xd, input logic xv,
                                input logic xe, input logic [15:0] xs);
        vec_t v;
        v.rst = r; v.en = e; v.emp = emp; v.rdata = d; v.busy = b;
        v.x_rinc = xr; v.x_data = xd; v.x_valid = xv; v.x_err = xe; v.x_sent = xs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic xr, input logic [7:0] xd,
                              input logic xv, input logic xe, input logic [15:0] xs);
        chk({tag, ".rinc"},  32'(bus.rinc),          32'(xr));
        chk({tag, ".data"},  32'(bus.tx_data),       32'(xd));
        chk({tag, ".valid"}, 32'(bus.tx_data_valid), 32'(xv));
        chk({tag, ".err"},   32'(tx_error),          32'(xe));
        chk({tag, ".sent"},  32'(sent_count),        32'(xs));
    endtask

    // Drive one cycle's inputs at the falling edge and let combinational outputs settle
    task automatic cyc(input logic r, input logic e, input logic emp,
                       input logic [7:0] d, input logic b);
        @(negedge clk);
        rst = r; enable = e; bus.rempty = emp; bus.rdata = d; bus.tx_busy = b;
        #1;
        n++;
    endtask

    // FIFO + TX traffic checked against the frame-level model
    task automatic run_traffic(input int ncyc, input bit rnd);
        logic b, e, emp, xr;
        logic [7:0] d;
        for (int k = 0; k < ncyc; k++) begin
            case (ph)
                1:       b = (stall_left > 0);
                2:       b = (rise > 0) && (ack_cnt >= rise);
                3:       b = (busy_left > 0);
                default: b = 1'b0;
            endcase
            e   = rnd ? ($urandom_range(0, 99) < 85) : 1'b1;
            emp = (q.size() == 0);
            d   = emp ? 8'($urandom) : q[0];
            cyc(1'b0, e, emp, d, b);
            xr = (ph == 0) && (n >= idle_at) && e && !emp;
            chk("tr.rinc",  32'(bus.rinc),          32'(xr));
            chk("tr.valid", 32'(bus.tx_data_valid), 32'((ph == 2) && (ack_cnt == 0)));
            chk("tr.data",  32'(bus.tx_data),       32'(m_data));
            chk("tr.err",   32'(tx_error),          32'(m_err));
            chk("tr.sent",  32'(sent_count),        32'(m_sent));
            if (bus.rinc) begin
                dut_pops++;
                if (last_fall >= 0 && (n - last_fall) < min_gap) min_gap = n - last_fall;
            end
            case (ph)
                0: if (xr) begin
                    m_data     = q.pop_front();
                    ph         = 1;
                    stall_left = (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                end
                1: if (!b) begin
                    ph      = 2;
                    ack_cnt = 0;
                    rise    = !rnd ? 1 : (($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3)));
                end else begin
                    stall_left--;
                end
                2: if (b) begin
                    ph        = 3;
                    busy_left = (rnd ? int'($urandom_range(1, 6)) : 4) - 1;
                end else if (ack_cnt == int'(TMO) - 1) begin
                    m_err   = 1'b1;
                    ph      = 0;
                    idle_at = n + 1;
                end else begin
                    ack_cnt++;
                end
                3: if (b) begin
                    busy_left--;
                end else begin
                    m_sent++;
                    ph        = 0;
                    idle_at   = n + 1 + int'(GAP);
                    last_fall = n;
                end
                default: ph = 0;
            endcase
            if (rnd && q.size() < 8 && $urandom_range(0, 2) == 0) q.push_back(8'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; bus.rempty = 1'b0; bus.rdata = 8'hA5; bus.tx_busy = 1'b0;

        // Reset, single word with a 10-cycle TX, enable gating, TX busy at load
        repeat (3) tbl.push_back(mk(1, 1, 0, 8'hA5, 0,  0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 0,  0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'hA5, 0,  1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h5A, 0,  0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 0,  0, 8'hA5, 1, 0, 0));
        repeat (10) tbl.push_back(mk(0, 1, 1, 8'h00, 1,  0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 0,  0, 8'hA5, 0, 0, 0));
        repeat (3) tbl.push_back(mk(0, 1, 1, 8'h00, 0,  0, 8'hA5, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h3C, 0,  0, 8'hA5, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h3C, 0,  1, 8'hA5, 0, 0, 1));
        repeat (5) tbl.push_back(mk(0, 1, 1, 8'h00, 1,  0, 8'h3C, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8'h00, 0,  0, 8'h3C, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8'h00, 0,  0, 8'h3C, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8'h00, 1,  0, 8'h3C, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8'h00, 0,  0, 8'h3C, 0, 0, 1));
        repeat (4) tbl.push_back(mk(0, 1, 1, 8'h00, 0,  0, 8'h3C, 0, 0, 2));

        cyc(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].en, tbl[i].emp, tbl[i].rdata, tbl[i].busy);
            expect_out($sformatf("tbl%0d", i), tbl[i].x_rinc, tbl[i].x_data,
                       tbl[i].x_valid, tbl[i].x_err, tbl[i].x_sent);
        end

        // TX never acknowledges: error after four cycles waiting, next word still goes out
        cyc(0, 1, 0, 8'h77, 0); expect_out("to_pop",   1, 8'h3C, 0, 0, 2);
        cyc(0, 1, 1, 8'h00, 0); expect_out("to_load",  0, 8'h77, 0, 0, 2);
        cyc(0, 1, 1, 8'h00, 0); expect_out("to_valid", 0, 8'h77, 1, 0, 2);
        cyc(0, 1, 1, 8'h00, 0); expect_out("to_w2",    0, 8'h77, 0, 0, 2);
        cyc(0, 1, 1, 8'h00, 0); expect_out("to_w3",    0, 8'h77, 0, 0, 2);
        cyc(0, 1, 1, 8'h00, 0); expect_out("to_w4",    0, 8'h77, 0, 0, 2);
        cyc(0, 1, 1, 8'h00, 0); expect_out("to_err",   0, 8'h77, 0, 1, 2);
        cyc(0, 1, 0, 8'h88, 0); expect_out("to_next",  1, 8'h77, 0, 1, 2);
        cyc(0, 1, 1, 8'h00, 0); expect_out("to_nload", 0, 8'h88, 0, 1, 2);
        cyc(0, 1, 1, 8'h00, 0); expect_out("to_nval",  0, 8'h88, 1, 1, 2);
        cyc(0, 1, 1, 8'h00, 1); expect_out("to_nbusy", 0, 8'h88, 0, 1, 2);
        cyc(0, 1, 1, 8'h00, 1); expect_out("to_nbusy", 0, 8'h88, 0, 1, 2);
        cyc(0, 1, 1, 8'h00, 0); expect_out("to_nfall", 0, 8'h88, 0, 1, 2);
        repeat (3) begin cyc(0, 1, 1, 8'h00, 0); expect_out("to_gap", 0, 8'h88, 0, 1, 3); end

        // Enable dropped mid-frame: frame completes, no further pop
        cyc(0, 1, 0, 8'h11, 0); expect_out("en_pop",   1, 8'h88, 0, 1, 3);
        cyc(0, 1, 1, 8'h00, 0); expect_out("en_load",  0, 8'h11, 0, 1, 3);
        cyc(0, 1, 1, 8'h00, 0); expect_out("en_valid", 0, 8'h11, 1, 1, 3);
        cyc(0, 0, 0, 8'h22, 1); expect_out("en_busy",  0, 8'h11, 0, 1, 3);
        cyc(0, 0, 0, 8'h22, 1); expect_out("en_busy",  0, 8'h11, 0, 1, 3);
        cyc(0, 0, 0, 8'h22, 0); expect_out("en_fall",  0, 8'h11, 0, 1, 3);
        repeat (5) begin cyc(0, 0, 0, 8'h22, 0); expect_out("en_hold", 0, 8'h11, 0, 1, 4); end

        // Reset while TX busy: everything clears, the frame is not counted
        cyc(0, 1, 0, 8'h22, 0); expect_out("rs_pop",   1, 8'h11, 0, 1, 4);
        cyc(0, 1, 1, 8'h00, 0); expect_out("rs_load",  0, 8'h22, 0, 1, 4);
        cyc(0, 1, 1, 8'h00, 0); expect_out("rs_valid", 0, 8'h22, 1, 1, 4);
        cyc(0, 1, 1, 8'h00, 1); expect_out("rs_busy",  0, 8'h22, 0, 1, 4);
        cyc(1, 1, 0, 8'h33, 1); expect_out("rs_rst",   0, 8'h22, 0, 1, 4);
        cyc(0, 1, 1, 8'h00, 1); expect_out("rs_after", 0, 8'h00, 0, 0, 0);
        cyc(0, 1, 1, 8'h00, 0); expect_out("rs_fall",  0, 8'h00, 0, 0, 0);
        cyc(0, 1, 1, 8'h00, 0); expect_out("rs_idle",  0, 8'h00, 0, 0, 0);

        // Three queued words back to back with the inter-frame gap
        m_data = 8'h00; m_err = 1'b0; m_sent = 16'd0;
        ph = 0; idle_at = 0; ack_cnt = 0; rise = 1; stall_left = 0; busy_left = 0;
        dut_pops = 0; last_fall = -1; min_gap = 1000;
        q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03);
        run_traffic(60, 1'b0);
        chk("b2b.pops",    32'(dut_pops),   32'd3);
        chk("b2b.min_gap", 32'(min_gap),    32'(GAP + 1));
        chk("b2b.sent",    32'(sent_count), 32'd3);

        // Randomised traffic: enable toggling, load stalls, variable TX, timeouts
        run_traffic(3000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
